pcpi_vec: RTL and testbench
===========================

# pcpi_vec

Vector coprocessor for the picorv32 core, attached through the PCPI port. It decodes a small RISC-V-V-style subset: `vsetvli`, strided vector load, element-wise `vadd` and multiply-accumulate `vdot`. It owns a 32-entry vector register file and a private word-wide memory master port, and returns scalar results (`vl`) to the CPU.

## Interface
- VLMAX, 4: maximum elements per vector register; element width is fixed at 32 bits.
- NREGS, 32: number of vector registers.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-high (asserted = 1), despite the historic name.
- pcpi_valid  in  1  CPU offers an instruction; held until `pcpi_ready`.
- pcpi_insn  in  32  instruction word.
- pcpi_cpurs1  in  32  scalar rs1 value (AVL or base address).
- pcpi_cpurs2  in  32  scalar rs2 value (byte stride).
- pcpi_wr  out  1  with `pcpi_ready`: write `pcpi_rd` to CPU rd.
- pcpi_rd  out  32  scalar result.
- pcpi_wait  out  1  instruction recognised, busy.
- pcpi_ready  out  1  one-cycle completion pulse.
- mem_valid  out  1  memory request, held until `mem_ready`.
- mem_ready  in  1  memory accepted; `mem_rdata` valid this cycle.
- mem_addr  out  32  byte address (word aligned).
- mem_wdata  out  32  store data.
- mem_wstrb  out  4  byte strobes; 0 = read.
- mem_rdata  in  32  read data.

## Operation
- Decode when `pcpi_valid` and idle:
  - `vsetvli`: opcode 1010111, funct3 111, insn[31]=0. vtype ← insn[30:20]; vl ← min(pcpi_cpurs1, VLMAX); `pcpi_rd`=vl, `pcpi_wr`=1.
  - `vls` (strided load): opcode 0000111, funct3 111, mop insn[27:26]=10. Element i ← mem[pcpi_cpurs1 + i·pcpi_cpurs2] into vd=insn[11:7], for i<vl. A stride of 0 broadcasts. `pcpi_wr`=0.
  - `vadd`: opcode 1010111, funct3 000, funct6 000000: vd[i] ← vs2[i] + vs1[i].
  - `vdot`: opcode 1010111, funct3 000, funct6 111001: vd[i] ← vd[i] + vs2[i]·vs1[i]. The multiply takes the low 32 bits; the sum wraps modulo 2^32.
  - Register fields: vs2=insn[24:20], vs1=insn[19:15], vd=insn[11:7].
- Elements i ≥ vl of vd are unchanged.
- Unrecognised instruction: no `pcpi_wait`, no `pcpi_ready`, so the CPU traps.
- State machine: IDLE → SETVL | LD_REQ | ALU.
  - SETVL → DONE.
  - LD_REQ ↔ LD_WAIT for each element, then → DONE.
  - ALU handles one element per cycle, then → DONE.
  - DONE pulses `pcpi_ready`, then → IDLE.
- vl=0: ALU and LD go straight to DONE with no memory access.
- Reset clears vl, vtype, state and all outputs to 0. Vector register contents are not reset.
- Reset mid-operation aborts immediately and drops `mem_valid`.

## Timing
- `pcpi_wait` is high from the cycle after `pcpi_valid` is accepted until `pcpi_ready`.
- vsetvli: `pcpi_ready` 2 cycles after acceptance.
- ALU ops: `pcpi_ready` at vl+2 cycles.
- Load: one memory transaction per element. `mem_valid` is held until the `mem_ready` cycle and deasserts the next cycle. The next address is issued in the following cycle.
- `pcpi_ready` and `pcpi_wr` are high for exactly one cycle. `pcpi_rd` is stable while `pcpi_ready` is high.
- A new instruction is accepted no earlier than the cycle after `pcpi_ready`.

## Configuration
- `PCPI_VEC_STORE_EN` defined: adds a strided store `vss` (opcode 0100111, funct3 111, mop 10).
  - For each i<vl, writes vs3=insn[11:7] element i to base + i·stride with `mem_wstrb`=1111.
  - Adds states ST_REQ and ST_WAIT.
- Not defined: opcode 0100111 is unrecognised, and `mem_wstrb` is tied to 0.

## Test plan
- rs1=3, vsetvli x4,x2 (0x00817257) → `pcpi_wr`=1, `pcpi_rd`=3. rs1=9 → `pcpi_rd`=4.
- vl=3, vls v1 with base 400, stride 12, over mem words 1..9 → addresses 400/412/424; v1 = {1,4,7}.
- vls v4 with base 440, stride 0, word 10 → three reads of 440; v4 = {10,10,10}.
- v8 loaded as zeros, then three vdot ops accumulating columns {1,4,7}·10, {2,5,8}·11, {3,6,9}·12 → v8 = {68,167,266}.
- vadd with vl=0 → ready after 2 cycles, no `mem_valid`, vd unchanged. Opcode 0x00000093 → `pcpi_wait` and `pcpi_ready` stay 0.
- Reset asserted during LD_WAIT → `mem_valid` and `pcpi_wait` are 0 and vl=0. After release, a vsetvli completes normally.

Source files
------------

// File: rtl/pcpi_vec.sv
// PCPI vector coprocessor: vsetvli, strided load, vadd and vdot over a private register file.
// Define PCPI_VEC_STORE_EN to add the strided store vss.
module pcpi_vec #(
  parameter int unsigned VLMAX = 4,
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_cpurs1,
  input  logic [31:0] pcpi_cpurs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned VlW  = $clog2(VLMAX + 1);
  localparam int unsigned IdxW = (VLMAX > 1) ? $clog2(VLMAX) : 1;

  typedef enum logic [2:0] {
    StIdle, StSetvl, StLdReq, StLdWait, StAlu, StDone, StStReq, StStWait
  } state_e;

  state_e         r_state;
  logic [VlW-1:0] r_vl;
  logic [VlW-1:0] r_idx;
  logic [10:0]    r_vtype;
  logic [4:0]     r_vd, r_vs1, r_vs2;
  logic           r_is_dot;
  logic [31:0]    r_rs1, r_stride, r_addr;
  logic           r_wr, r_wait, r_ready, r_mem_valid;
  logic [31:0]    r_rd;
  logic [31:0]    r_vrf [NREGS][VLMAX];

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [5:0]      w_f6;
  logic            w_is_setvl, w_is_vls, w_is_valu, w_is_vadd, w_is_vdot, w_is_vss, w_accept;
  logic [IdxW-1:0] w_elem;
  logic [31:0]     w_a, w_b, w_d, w_alu, w_rf_data;
  logic            w_rf_we;
  logic [VlW-1:0]  w_new_vl;
  logic            w_unused;

  assign w_opcode   = pcpi_insn[6:0];
  assign w_f3       = pcpi_insn[14:12];
  assign w_f6       = pcpi_insn[31:26];
  assign w_is_setvl = (w_opcode == 7'b1010111) && (w_f3 == 3'b111) && !pcpi_insn[31];
  assign w_is_vls   = (w_opcode == 7'b0000111) && (w_f3 == 3'b111) && (pcpi_insn[27:26] == 2'b10);
  assign w_is_valu  = (w_opcode == 7'b1010111) && (w_f3 == 3'b000);
  assign w_is_vadd  = w_is_valu && (w_f6 == 6'b000000);
  assign w_is_vdot  = w_is_valu && (w_f6 == 6'b111001);
`ifdef PCPI_VEC_STORE_EN
  assign w_is_vss   = (w_opcode == 7'b0100111) && (w_f3 == 3'b111) && (pcpi_insn[27:26] == 2'b10);
`else
  assign w_is_vss   = 1'b0;
`endif
  assign w_accept   = pcpi_valid && (r_state == StIdle) &&
                      (w_is_setvl || w_is_vls || w_is_vadd || w_is_vdot || w_is_vss);

  assign w_new_vl = (r_rs1 > 32'(VLMAX)) ? VlW'(VLMAX) : r_rs1[VlW-1:0];
  assign w_elem   = r_idx[IdxW-1:0];
  assign w_a      = r_vrf[r_vs2][w_elem];
  assign w_b      = r_vrf[r_vs1][w_elem];
  assign w_d      = r_vrf[r_vd][w_elem];
  assign w_alu    = r_is_dot ? (w_d + w_a * w_b) : (w_a + w_b);
  assign w_unused = ^r_vtype;

  // Writes are suppressed while reset is held so an aborted op leaves vd alone.
  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_data = w_alu;
    if (!resetn) begin
      if (r_state == StAlu && r_idx < r_vl) begin
        w_rf_we = 1'b1;
      end else if (r_state == StLdWait && mem_ready) begin
        w_rf_we   = 1'b1;
        w_rf_data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_we) r_vrf[r_vd][w_elem] <= w_rf_data;
  end

`ifdef PCPI_VEC_STORE_EN
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
`else
  assign mem_wdata = '0;
  assign mem_wstrb = '0;
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= StIdle;
      r_vl        <= '0;
      r_idx       <= '0;
      r_vtype     <= '0;
      r_vd        <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_is_dot    <= 1'b0;
      r_rs1       <= '0;
      r_stride    <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_rd        <= '0;
      r_wait      <= 1'b0;
      r_ready     <= 1'b0;
      r_mem_valid <= 1'b0;
`ifdef PCPI_VEC_STORE_EN
      r_wdata     <= '0;
      r_wstrb     <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_vd     <= pcpi_insn[11:7];
            r_vs1    <= pcpi_insn[19:15];
            r_vs2    <= pcpi_insn[24:20];
            r_rs1    <= pcpi_cpurs1;
            r_addr   <= pcpi_cpurs1;
            r_stride <= pcpi_cpurs2;
            r_is_dot <= w_is_vdot;
            r_idx    <= '0;
            r_wait   <= 1'b1;
            if (w_is_setvl) begin
              r_vtype <= pcpi_insn[30:20];
              r_state <= StSetvl;
            end else if (w_is_vls) begin
              r_state <= StLdReq;
            end else if (w_is_vss) begin
              r_state <= StStReq;
            end else begin
              r_state <= StAlu;
            end
          end
        end
        StSetvl: begin
          r_vl    <= w_new_vl;
          r_rd    <= 32'(w_new_vl);
          r_wr    <= 1'b1;
          r_ready <= 1'b1;
          r_wait  <= 1'b0;
          r_state <= StDone;
        end
        StLdReq: begin
          if (r_idx >= r_vl) begin
            r_ready <= 1'b1;
            r_wait  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_mem_valid <= 1'b1;
            r_state     <= StLdWait;
          end
        end
        StLdWait: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_idx       <= r_idx + VlW'(1);
            r_addr      <= r_addr + r_stride;
            r_state     <= StLdReq;
          end
        end
        StAlu: begin
          if (r_idx < r_vl) begin
            r_idx <= r_idx + VlW'(1);
          end else begin
            r_ready <= 1'b1;
            r_wait  <= 1'b0;
            r_state <= StDone;
          end
        end
`ifdef PCPI_VEC_STORE_EN
        StStReq: begin
          if (r_idx >= r_vl) begin
            r_ready <= 1'b1;
            r_wait  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_mem_valid <= 1'b1;
            r_wstrb     <= 4'b1111;
            r_wdata     <= w_d;
            r_state     <= StStWait;
          end
        end
        StStWait: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_wstrb     <= 4'b0000;
            r_idx       <= r_idx + VlW'(1);
            r_addr      <= r_addr + r_stride;
            r_state     <= StStReq;
          end
        end
`endif
        StDone: begin
          r_ready <= 1'b0;
          r_wr    <= 1'b0;
          r_rd    <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign pcpi_wr    = r_wr;
  assign pcpi_rd    = r_rd;
  assign pcpi_wait  = r_wait;
  assign pcpi_ready = r_ready;
  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_addr;

endmodule

// File: tb/tb_pcpi_vec.sv
// Bench for pcpi_vec: directed scenarios plus random instruction mix against an
// array-based model of the vector state and a word memory with random latency.
module tb_pcpi_vec;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_cpurs1 = '0;
  logic [31:0] pcpi_cpurs2 = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, mem_valid;
  logic [31:0] pcpi_rd, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  pcpi_vec dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_cpurs1(pcpi_cpurs1),
    .pcpi_cpurs2(pcpi_cpurs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [0:255];
  logic [31:0] ref_vrf [32][4];
  int unsigned ref_vl;
  logic [31:0] addr_q [$];
  int          n_memv;
  bit          mem_hold;
  int          total, bad;

  // Memory slave: random 0..2 cycle latency, one-cycle ready pulse.
  initial begin
    int delay;
    delay = 0;
    n_memv = 0;
    mem_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid) n_memv++;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid && !mem_hold) begin
        if (delay == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          addr_q.push_back(mem_addr);
          if (mem_wstrb != 4'b0) mem[mem_addr[9:2]] = mem_wdata;
          delay = $urandom_range(0, 2);
        end else begin
          delay--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_reg(input logic [4:0] vd);
    for (int e = 0; e < 4; e++) check($sformatf("v%0d[%0d]", vd, e), dut.r_vrf[vd][e], ref_vrf[vd][e]);
  endtask

  function automatic logic [31:0] enc_vls(input logic [4:0] vd);
    return {6'b000010, 1'b0, 5'd2, 5'd1, 3'b111, vd, 7'b0000111};
  endfunction

  function automatic logic [31:0] enc_valu(input bit dot, input logic [4:0] vd,
                                           input logic [4:0] vs1, input logic [4:0] vs2);
    return {(dot ? 6'b111001 : 6'b000000), 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  task automatic run_insn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                          output int cyc, output logic wr, output logic [31:0] rd,
                          output logic saw_wait);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn;
    pcpi_cpurs1 = rs1;
    pcpi_cpurs2 = rs2;
    cyc = 0;
    wr = 1'b0;
    rd = '0;
    saw_wait = 1'b0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) saw_wait = pcpi_wait;
      if (pcpi_ready) begin
        wr = pcpi_wr;
        rd = pcpi_rd;
        break;
      end
    end
    pcpi_valid = 1'b0;
    if (!pcpi_ready) begin
      check("ready_timeout", 32'(pcpi_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      check("ready_pulse", {pcpi_ready, pcpi_wr}, 32'd0);
    end
  endtask

  task automatic do_setvl(input logic [31:0] rs1);
    int cyc;
    logic wr, sw;
    logic [31:0] rd;
    run_insn(32'h00817257, rs1, 32'd0, cyc, wr, rd, sw);
    ref_vl = (rs1 > 32'd4) ? 4 : rs1;
    check("setvl_wr", 32'(wr), 32'd1);
    check("setvl_rd", rd, ref_vl);
    check("setvl_cycles", cyc, 32'd2);
    check("setvl_wait", 32'(sw), 32'd1);
  endtask

  task automatic do_vls(input logic [4:0] vd, input logic [31:0] base, input logic [31:0] stride);
    int cyc;
    logic wr, sw;
    logic [31:0] rd, a;
    addr_q.delete();
    for (int i = 0; i < int'(ref_vl); i++) begin
      a = base + 32'(i) * stride;
      ref_vrf[vd][i] = mem[a[9:2]];
    end
    run_insn(enc_vls(vd), base, stride, cyc, wr, rd, sw);
    check("vls_wr", 32'(wr), 32'd0);
    check("vls_count", addr_q.size(), ref_vl);
    for (int i = 0; i < int'(ref_vl) && i < addr_q.size(); i++)
      check($sformatf("vls_addr%0d", i), addr_q[i], base + 32'(i) * stride);
    check_reg(vd);
  endtask

  task automatic do_alu(input bit dot, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2);
    int cyc;
    logic wr, sw;
    logic [31:0] rd;
    logic [31:0] nv [4];
    for (int i = 0; i < 4; i++) begin
      nv[i] = ref_vrf[vd][i];
      if (i < int'(ref_vl))
        nv[i] = dot ? ref_vrf[vd][i] + ref_vrf[vs2][i] * ref_vrf[vs1][i]
                    : ref_vrf[vs2][i] + ref_vrf[vs1][i];
    end
    for (int i = 0; i < 4; i++) ref_vrf[vd][i] = nv[i];
    run_insn(enc_valu(dot, vd, vs1, vs2), 32'd0, 32'd0, cyc, wr, rd, sw);
    check(dot ? "vdot_cycles" : "vadd_cycles", cyc, ref_vl + 2);
    check("alu_wr", 32'(wr), 32'd0);
    check_reg(vd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, m;
    logic any;
    total = 0;
    bad = 0;
    ref_vl = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 9; i++) mem[100 + i] = 32'(i + 1);
    mem[110] = 32'd10;
    mem[111] = 32'd11;
    mem[112] = 32'd12;
    for (int i = 120; i < 124; i++) mem[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {pcpi_wait, pcpi_ready, pcpi_wr, mem_valid}, 32'd0);
    check("rst_rd", pcpi_rd, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    resetn = 1'b0;

    // Reset-state vl is 0: an ALU op finishes in 2 cycles with no memory traffic.
    m = n_memv;
    do_alu(1'b0, 5'd0, 5'd0, 5'd0);
    check("vl0_nomem", n_memv, m);

    do_setvl(32'd3);
    do_setvl(32'd9);
    do_setvl(32'hFFFF_FFFF);
    for (int r = 0; r < 32; r++) do_vls(5'(r), 32'(r * 16), 32'd4);

    do_setvl(32'd3);
    do_vls(5'd1, 32'd400, 32'd12);
    do_vls(5'd2, 32'd404, 32'd12);
    do_vls(5'd3, 32'd408, 32'd12);
    do_vls(5'd4, 32'd440, 32'd0);
    do_vls(5'd5, 32'd444, 32'd0);
    do_vls(5'd6, 32'd448, 32'd0);
    do_vls(5'd8, 32'd480, 32'd4);
    do_alu(1'b1, 5'd8, 5'd1, 5'd4);
    do_alu(1'b1, 5'd8, 5'd2, 5'd5);
    do_alu(1'b1, 5'd8, 5'd3, 5'd6);
    check("vdot_e0", dut.r_vrf[8][0], 32'd68);
    check("vdot_e1", dut.r_vrf[8][1], 32'd167);
    check("vdot_e2", dut.r_vrf[8][2], 32'd266);

    do_setvl(32'd0);
    m = n_memv;
    do_alu(1'b0, 5'd8, 5'd1, 5'd2);
    do_vls(5'd9, 32'd0, 32'd4);
    check("vl0_nomem2", n_memv, m);

    // Unrecognised opcode must never raise wait or ready.
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = 32'h00000093;
    any = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      any = any | pcpi_wait | pcpi_ready;
    end
    pcpi_valid = 1'b0;
    check("unrec_silent", 32'(any), 32'd0);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2) do_setvl(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6)));
      else if (k < 5) do_vls(5'($urandom_range(0, 31)), 32'($urandom_range(0, 200) * 4),
                             32'($urandom_range(0, 4) * 4));
      else do_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset while a load waits on memory.
    do_setvl(32'd3);
    mem_hold = 1'b1;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = enc_vls(5'd20);
    pcpi_cpurs1 = 32'd600;
    pcpi_cpurs2 = 32'd4;
    k = 0;
    while (!mem_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ldwait_reached", 32'(mem_valid), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("abort_mem_valid", 32'(mem_valid), 32'd0);
    check("abort_wait", 32'(pcpi_wait), 32'd0);
    check("abort_ready", 32'(pcpi_ready), 32'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    mem_hold = 1'b0;
    ref_vl = 0;
    check_reg(5'd20);
    m = n_memv;
    do_alu(1'b0, 5'd20, 5'd1, 5'd2);
    check("post_rst_nomem", n_memv, m);
    do_setvl(32'd9);
    do_vls(5'd20, 32'd400, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
